// File: rtl/mcu_bus_pkg.sv
// Shared constants and types for the MCU parallel-bus receiver.
// A FIFO entry is packed as {is_command, data}, DATA_WIDTH+1 bits wide.
package mcu_bus_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FIFO_DEPTH  = 16;
  localparam int DEF_BUSY_MARGIN = 4;

  localparam bit EDGE_RISING  = 1'b1;
  localparam bit EDGE_FALLING = 1'b0;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/mcu_bus_fifo.sv
// First-word-fall-through synchronous FIFO; occupancy tracked by a counter and
// a three-state machine whose state is exported for debug and for out_valid.
module mcu_bus_fifo
  import mcu_bus_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    level_next,
  output logic             dropped,
  output fifo_state_e      state
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    pop_ok     = pop && (state != FIFO_EMPTY);
    push_ok    = push && ((state != FIFO_FULL) || pop_ok);
    dropped    = push && !push_ok;
    level_next = level;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  assign rdata = (state == FIFO_EMPTY) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      state  <= FIFO_EMPTY;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      case (state)
        FIFO_EMPTY:   if (push_ok) state <= FIFO_PARTIAL;
        FIFO_PARTIAL: begin
          if (level_next == LW'(DEPTH)) state <= FIFO_FULL;
          else if (level_next == '0)    state <= FIFO_EMPTY;
        end
        FIFO_FULL:    if (pop_ok && !push_ok) state <= FIFO_PARTIAL;
        default:      state <= FIFO_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/mcu_bus_rx.sv
// MCU parallel-bus receiver: synchronises the bus into sysclk, captures a tagged
// word on the chosen busclk edge and hands it out through a FWFT FIFO.
module mcu_bus_rx
  import mcu_bus_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int BUSY_MARGIN  = DEF_BUSY_MARGIN,
  parameter bit CAPTURE_EDGE = EDGE_RISING
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          busclk,
  input  logic [DATA_WIDTH-1:0]         bus,
  input  logic                          enable,
  input  logic                          command_data,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_is_command,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int EW = entry_width(DATA_WIDTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] en_sync;
  logic [SYNC_STAGES-1:0] cd_sync;
  logic [DATA_WIDTH-1:0]  bus_sync [SYNC_STAGES];
  logic                   clk_hist;
  logic                   clk_s;
  logic                   edge_event;
  logic                   cap_push;
  logic [EW-1:0]          cap_word;
  logic [EW-1:0]          head;
  logic [LW-1:0]          level_next;
  logic                   dropped;
  fifo_state_e            fifo_state;

  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign edge_event = (CAPTURE_EDGE == EDGE_RISING) ? (clk_s && !clk_hist)
                                                    : (!clk_s && clk_hist);

  // Synchronisers plus a capture register so the FIFO write sees a clean word.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      en_sync  <= '0;
      cd_sync  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) bus_sync[i] <= '0;
      clk_hist <= 1'b0;
      cap_push <= 1'b0;
      cap_word <= '0;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], busclk};
      en_sync     <= {en_sync[SYNC_STAGES-2:0], enable};
      cd_sync     <= {cd_sync[SYNC_STAGES-2:0], command_data};
      bus_sync[0] <= bus;
      for (int i = 1; i < SYNC_STAGES; i++) bus_sync[i] <= bus_sync[i-1];
      clk_hist <= clk_s;
      cap_push <= edge_event && en_sync[SYNC_STAGES-1];
      cap_word <= {cd_sync[SYNC_STAGES-1], bus_sync[SYNC_STAGES-1]};
    end
  end

  mcu_bus_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk        (sysclk),
    .rst        (reset),
    .push       (cap_push),
    .pop        (out_valid && out_ready),
    .wdata      (cap_word),
    .rdata      (head),
    .level      (fifo_level),
    .level_next (level_next),
    .dropped    (dropped),
    .state      (fifo_state)
  );

  assign out_valid      = (fifo_state != FIFO_EMPTY);
  assign out_data       = head[DATA_WIDTH-1:0];
  assign out_is_command = head[DATA_WIDTH];

  // busy tracks the level the FIFO is about to hold, so it lines up with fifo_level.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= (FIFO_DEPTH - int'(level_next)) <= BUSY_MARGIN;
      if (dropped)             overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcu_bus_rx.sv
// Directed bench for mcu_bus_rx: a rising-edge build and a falling-edge build
// share all inputs; expected words are kept in exp_q.
module tb_mcu_bus_rx;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       busclk = 1'b0;
  logic [7:0] bus = 8'h00;
  logic       enable = 1'b0;
  logic       command_data = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear_overflow = 1'b0;

  logic [7:0] r_out_data, f_out_data;
  logic       r_out_is_command, f_out_is_command;
  logic       r_out_valid, f_out_valid;
  logic [4:0] r_fifo_level, f_fifo_level;
  logic       r_busy, f_busy;
  logic       r_overflow, f_overflow;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 sysclk = ~sysclk;

  mcu_bus_rx #(.CAPTURE_EDGE(1'b1)) u_dut (
    .sysclk(sysclk), .reset(reset), .busclk(busclk), .bus(bus), .enable(enable),
    .command_data(command_data), .out_data(r_out_data), .out_is_command(r_out_is_command),
    .out_valid(r_out_valid), .out_ready(out_ready), .fifo_level(r_fifo_level),
    .busy(r_busy), .overflow(r_overflow), .clear_overflow(clear_overflow)
  );

  mcu_bus_rx #(.CAPTURE_EDGE(1'b0)) u_dut_fall (
    .sysclk(sysclk), .reset(reset), .busclk(busclk), .bus(bus), .enable(enable),
    .command_data(command_data), .out_data(f_out_data), .out_is_command(f_out_is_command),
    .out_valid(f_out_valid), .out_ready(out_ready), .fifo_level(f_fifo_level),
    .busy(f_busy), .overflow(f_overflow), .clear_overflow(clear_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic write_word(input logic [7:0] d, input logic cmd);
    bus = d;
    command_data = cmd;
    enable = 1'b1;
    tick(3);
    busclk = 1'b1;
    tick(4);
    busclk = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    busclk = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;
    clear_overflow = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    exp_q.delete();
  endtask

  task automatic drain_and_check(input string tag);
    int n;
    n = exp_q.size();
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_valid"}, r_out_valid, 1'b1);
      check_eq({tag, "_data"}, r_out_data, exp_q.pop_front());
      tick(1);
    end
    out_ready = 1'b0;
    check_eq({tag, "_empty"}, r_out_valid, 1'b0);
    check_eq({tag, "_level0"}, r_fifo_level, 5'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  found;
    bit  seen;

    tick(2);
    check_eq("rst_valid", r_out_valid, 1'b0);
    check_eq("rst_level", r_fifo_level, 5'd0);
    check_eq("rst_busy", r_busy, 1'b0);
    check_eq("rst_overflow", r_overflow, 1'b0);
    check_eq("rst_data", r_out_data, 8'h00);
    check_eq("rst_is_cmd", r_out_is_command, 1'b0);
    reset = 1'b0;
    tick(1);

    // Single command write: out_valid rises SYNC_STAGES+2 = 4 cycles after the edge.
    bus = 8'hA5;
    command_data = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    tick(3);
    busclk = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= 8 && !found; i++) begin
      tick(1);
      if (r_out_valid) begin
        lat = i;
        found = 1'b1;
        check_eq("single_data", r_out_data, 8'hA5);
        check_eq("single_is_cmd", r_out_is_command, 1'b1);
      end
    end
    check_eq("single_latency", lat, 4);
    tick(1);
    check_eq("single_pulse", r_out_valid, 1'b0);
    busclk = 1'b0;
    out_ready = 1'b0;
    tick(4);

    // Edges with enable low are ignored.
    enable = 1'b0;
    bus = 8'hFF;
    seen = 1'b0;
    repeat (4) begin
      tick(3);
      busclk = 1'b1;
      repeat (3) begin tick(1); seen |= r_out_valid; end
      busclk = 1'b0;
      repeat (3) begin tick(1); seen |= r_out_valid; end
    end
    check_eq("gate_valid_seen", seen, 1'b0);
    check_eq("gate_level", r_fifo_level, 5'd0);

    // Burst of 12 under backpressure; busy asserts once free entries <= 4.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      write_word(8'(i), 1'b0);
      exp_q.push_back(8'(i));
      if (i == 10) check_eq("burst_busy11", r_busy, 1'b0);
    end
    check_eq("burst_level12", r_fifo_level, 5'd12);
    check_eq("burst_busy12", r_busy, 1'b1);
    out_ready = 1'b1;
    check_eq("burst_head", r_out_data, 8'h00);
    void'(exp_q.pop_front());
    tick(1);
    check_eq("burst_level11", r_fifo_level, 5'd11);
    check_eq("burst_busy_drop", r_busy, 1'b0);
    drain_and_check("burst");

    // Overflow: 17th word is dropped, head stays word 0.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      write_word(8'h40 + 8'(i), 1'b0);
      if (i < 16) exp_q.push_back(8'h40 + 8'(i));
      if (i == 15) begin
        check_eq("ovf_full_level", r_fifo_level, 5'd16);
        check_eq("ovf_not_yet", r_overflow, 1'b0);
      end
    end
    check_eq("ovf_level", r_fifo_level, 5'd16);
    check_eq("ovf_flag", r_overflow, 1'b1);
    check_eq("ovf_head", r_out_data, 8'h40);
    check_eq("ovf_busy", r_busy, 1'b1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check_eq("ovf_cleared", r_overflow, 1'b0);
    drain_and_check("ovf");

    // Full FIFO with pop in the same cycle as the push: nothing dropped.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      write_word(8'h60 + 8'(i), 1'b0);
      exp_q.push_back(8'h60 + 8'(i));
    end
    bus = 8'h7F;
    command_data = 1'b1;
    tick(3);
    busclk = 1'b1;
    tick(3);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check_eq("fullpp_level", r_fifo_level, 5'd16);
    check_eq("fullpp_overflow", r_overflow, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h7F);
    busclk = 1'b0;
    tick(4);
    drain_and_check("fullpp");

    // Asynchronous reset in the middle of a burst.
    do_reset();
    for (int i = 0; i < 5; i++) write_word(8'h10 + 8'(i), 1'b1);
    check_eq("midrst_pre_level", r_fifo_level, 5'd5);
    reset = 1'b1;
    #1;
    check_eq("midrst_valid", r_out_valid, 1'b0);
    check_eq("midrst_level", r_fifo_level, 5'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    write_word(8'h3C, 1'b0);
    check_eq("midrst_post_valid", r_out_valid, 1'b1);
    check_eq("midrst_post_data", r_out_data, 8'h3C);
    check_eq("midrst_post_level", r_fifo_level, 5'd1);

    // Falling-edge build captures only on the busclk fall.
    do_reset();
    bus = 8'h5A;
    command_data = 1'b1;
    enable = 1'b1;
    tick(3);
    busclk = 1'b1;
    tick(5);
    check_eq("fall_rise_valid", f_out_valid, 1'b0);
    check_eq("fall_rise_level", f_fifo_level, 5'd0);
    check_eq("rise_build_level", r_fifo_level, 5'd1);
    busclk = 1'b0;
    tick(5);
    check_eq("fall_valid", f_out_valid, 1'b1);
    check_eq("fall_data", f_out_data, 8'h5A);
    check_eq("fall_is_cmd", f_out_is_command, 1'b1);
    check_eq("fall_level", f_fifo_level, 5'd1);
    check_eq("rise_build_level_after", r_fifo_level, 5'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
